// File: rtl/lnrv_ifu_fetch_pkg.sv
// Shared constants for the lnrv instruction-fetch front end.
package lnrv_ifu_fetch_pkg;

  localparam int          LP_INSTR_W = 32;
  localparam logic [31:0] LP_PC_INC  = 32'd4;

  function automatic logic pc_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/lnrv_ifu_fetch_if.sv
// Fetch unit bundle: cmd/rsp instruction bus plus the instruction stream towards the IDU.
interface lnrv_ifu_fetch_if;
  import lnrv_ifu_fetch_pkg::*;

  logic                  ifu_cmd_vld;
  logic                  ifu_cmd_rdy;
  logic [31:0]           ifu_cmd_addr;
  logic                  ifu_rsp_vld;
  logic                  ifu_rsp_rdy;
  logic [LP_INSTR_W-1:0] ifu_rsp_data;
  logic                  ifu_rsp_err;
  logic                  ifu_ir_vld;
  logic                  ifu_ir_rdy;
  logic [LP_INSTR_W-1:0] ifu_ir;
  logic [31:0]           ifu_pc;
  logic                  ifu_misalgn;
  logic                  ifu_buserr;

  modport master (
    output ifu_cmd_vld, ifu_cmd_addr, ifu_rsp_rdy,
           ifu_ir_vld, ifu_ir, ifu_pc, ifu_misalgn, ifu_buserr,
    input  ifu_cmd_rdy, ifu_rsp_vld, ifu_rsp_data, ifu_rsp_err, ifu_ir_rdy
  );

  modport slave (
    input  ifu_cmd_vld, ifu_cmd_addr, ifu_rsp_rdy,
           ifu_ir_vld, ifu_ir, ifu_pc, ifu_misalgn, ifu_buserr,
    output ifu_cmd_rdy, ifu_rsp_vld, ifu_rsp_data, ifu_rsp_err, ifu_ir_rdy
  );

endinterface

// File: rtl/lnrv_ifu_fetch.sv
// Instruction fetch: issues word fetches, tags returned words with their PC, and handles
// halt, flush/redirect (with discard of in-flight responses), misaligned PC and bus errors.
module lnrv_ifu_fetch
  import lnrv_ifu_fetch_pkg::*;
#(
  parameter logic [31:0] P_RESET_PC = 32'h0000_0000,
  parameter int          P_OUTS     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_halt_req,
  output logic        pipe_halt_ack,
  input  logic        pipe_flush_req,
  output logic        pipe_flush_ack,
  input  logic [31:0] flush_pc,
  lnrv_ifu_fetch_if.master ifu
);

  localparam int            CW      = $clog2(P_OUTS + 1);
  localparam int            DCW     = CW + 2;
  localparam logic [CW-1:0] LP_OUTS = CW'(P_OUTS);
  localparam int            LP_DMAX = (1 << DCW) - 1;

  logic [31:0]           fetch_pc_q, fetch_pc_d;
  logic [31:0]           rsp_pc_q,   rsp_pc_d;
  logic [CW-1:0]         cnt_q,      cnt_d;
  logic [DCW-1:0]        dcnt_q,     dcnt_d;
  logic                  stop_q,     stop_d;
  logic                  ir_vld_q,   ir_vld_d;
  logic [LP_INSTR_W-1:0] ir_q,       ir_d;
  logic [31:0]           pc_q,       pc_d;
  logic                  misalgn_q,  misalgn_d;
  logic                  buserr_q,   buserr_d;

  logic stage_free, cmd_vld, rsp_rdy, cmd_hs, rsp_hs, rsp_live, rsp_drop, misalgn_ld;
  int   dsum;

  always_comb begin
    stage_free = ~ir_vld_q | ifu.ifu_ir_rdy;
    cmd_vld    = ~reset & ~pipe_flush_req & ~pipe_halt_req & ~stop_q &
                 (cnt_q < LP_OUTS) & pc_aligned(fetch_pc_q);
    rsp_rdy    = ~reset & ((dcnt_q != '0) | stage_free);
    cmd_hs     = cmd_vld & ifu.ifu_cmd_rdy;
    rsp_hs     = ifu.ifu_rsp_vld & rsp_rdy;
    rsp_live   = rsp_hs & (dcnt_q == '0);
    rsp_drop   = rsp_hs & (dcnt_q != '0);
    misalgn_ld = ~pc_aligned(fetch_pc_q) & ~stop_q & (cnt_q == '0) &
                 (dcnt_q == '0) & stage_free;
    dsum       = int'(dcnt_q) + int'(cnt_q) - int'(rsp_hs);

    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    stop_d     = stop_q;
    ir_vld_d   = ir_vld_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    misalgn_d  = misalgn_q;
    buserr_d   = buserr_q;
    dcnt_d     = rsp_drop ? (dcnt_q - DCW'(1)) : dcnt_q;

    case ({cmd_hs, rsp_live})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (cmd_hs) fetch_pc_d = fetch_pc_q + LP_PC_INC;
    if (ir_vld_q & ifu.ifu_ir_rdy) ir_vld_d = 1'b0;

    if (rsp_live) begin
      ir_vld_d  = 1'b1;
      ir_d      = ifu.ifu_rsp_err ? '0 : ifu.ifu_rsp_data;
      pc_d      = rsp_pc_q;
      misalgn_d = 1'b0;
      buserr_d  = ifu.ifu_rsp_err;
      rsp_pc_d  = rsp_pc_q + LP_PC_INC;
      if (ifu.ifu_rsp_err) stop_d = 1'b1;
    end else if (misalgn_ld) begin
      ir_vld_d  = 1'b1;
      ir_d      = '0;
      pc_d      = fetch_pc_q;
      misalgn_d = 1'b1;
      buserr_d  = 1'b0;
      stop_d    = 1'b1;
    end

    // Redirect: every live request still on the bus moves into the discard window.
    if (pipe_flush_req) begin
      fetch_pc_d = flush_pc;
      rsp_pc_d   = flush_pc;
      stop_d     = 1'b0;
      cnt_d      = '0;
      ir_vld_d   = 1'b0;
      ir_d       = '0;
      pc_d       = '0;
      misalgn_d  = 1'b0;
      buserr_d   = 1'b0;
      if (dsum < 0)            dcnt_d = '0;
      else if (dsum > LP_DMAX) dcnt_d = '1;
      else                     dcnt_d = DCW'(dsum);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= P_RESET_PC;
      rsp_pc_q   <= P_RESET_PC;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      stop_q     <= 1'b0;
      ir_vld_q   <= 1'b0;
      ir_q       <= '0;
      pc_q       <= '0;
      misalgn_q  <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      stop_q     <= stop_d;
      ir_vld_q   <= ir_vld_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      misalgn_q  <= misalgn_d;
      buserr_q   <= buserr_d;
    end
  end

  assign ifu.ifu_cmd_vld  = cmd_vld;
  assign ifu.ifu_cmd_addr = fetch_pc_q;
  assign ifu.ifu_rsp_rdy  = rsp_rdy;
  assign ifu.ifu_ir_vld   = ir_vld_q;
  assign ifu.ifu_ir       = ir_q;
  assign ifu.ifu_pc       = pc_q;
  assign ifu.ifu_misalgn  = misalgn_q;
  assign ifu.ifu_buserr   = buserr_q;

  assign pipe_halt_ack  = ~reset & pipe_halt_req & (cnt_q == '0);
  assign pipe_flush_ack = pipe_flush_req;

endmodule

// File: tb/tb_lnrv_ifu_fetch.sv
// Randomized bench for lnrv_ifu_fetch: bus/IDU stimulus with a fetch-stream reference model
// feeding a scoreboard; a separate monitor checks every instruction handed to the IDU.
module tb_lnrv_ifu_fetch;
  import lnrv_ifu_fetch_pkg::*;

  localparam int P_OUTS = 2;
  localparam int N_RAND = 3000;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    logic [31:0] data;
    logic        err;
    int          due;
  } bus_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        misalgn;
    logic        buserr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt_req, halt_ack, flush_req, flush_ack;
  logic [31:0] flush_pc;

  lnrv_ifu_fetch_if ifu ();

  lnrv_ifu_fetch #(.P_RESET_PC(32'h0000_0000), .P_OUTS(P_OUTS)) dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_halt_req  (halt_req),
    .pipe_halt_ack  (halt_ack),
    .pipe_flush_req (flush_req),
    .pipe_flush_ack (flush_ack),
    .flush_pc       (flush_pc),
    .ifu            (ifu)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   delivered = 0;
  exp_t exp_q[$];
  bus_t bq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every IDU handshake.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #1;
      if (!reset && ifu.ifu_ir_vld && ifu.ifu_ir_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ir_unexpected: got pc %h want no instruction", ifu.ifu_pc);
        end else begin
          e = exp_q.pop_front();
          chk("ir", ifu.ifu_ir, e.ir);
          chk("pc", ifu.ifu_pc, e.pc);
          chk1("misalgn", ifu.ifu_misalgn, e.misalgn);
          chk1("buserr", ifu.ifu_buserr, e.buserr);
          delivered++;
        end
      end
    end
  end

  // Stimulus, bus responder and reference model of the fetch stream.
  initial begin
    int          cyc, epoch, mcnt, halt_left, drain;
    logic [31:0] mpc;
    logic        mstop, taken, draining, done, cmd_hs, rsp_hs;
    bus_t        b;
    cyc = 0; epoch = 0; mcnt = 0; halt_left = 0; drain = 0;
    mpc = 32'h0; mstop = 1'b0; taken = 1'b0; draining = 1'b0; done = 1'b0;

    reset = 1'b1; halt_req = 1'b1; flush_req = 1'b0; flush_pc = 32'h0;
    ifu.ifu_cmd_rdy = 1'b0; ifu.ifu_rsp_vld = 1'b0; ifu.ifu_rsp_data = 32'h0;
    ifu.ifu_rsp_err = 1'b0; ifu.ifu_ir_rdy = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk1("rst_cmd_vld", ifu.ifu_cmd_vld, 1'b0);
    chk1("rst_rsp_rdy", ifu.ifu_rsp_rdy, 1'b0);
    chk1("rst_ir_vld", ifu.ifu_ir_vld, 1'b0);
    chk1("rst_halt_ack", halt_ack, 1'b0);
    chk1("rst_flush_ack", flush_ack, 1'b0);
    chk("rst_cmd_addr", ifu.ifu_cmd_addr, 32'h0);
    chk("rst_ir", ifu.ifu_ir, 32'h0);
    flush_req = 1'b1;
    #1;
    chk1("rst_flush_ack_follow", flush_ack, 1'b1);
    flush_req = 1'b0;

    @(negedge clk);
    reset = 1'b0;
    halt_req = 1'b0;

    while (!done) begin
      if (!draining) begin
        if (halt_left > 0) halt_left--;
        else if ($urandom_range(0, 39) == 0) halt_left = $urandom_range(3, 15);
        halt_req  = (halt_left > 0);
        flush_req = ($urandom_range(0, 24) == 0);
        case ($urandom_range(0, 9))
          0:       flush_pc = 32'hFFFF_FFF8;
          1:       flush_pc = (32'h100 + 32'($urandom_range(0, 63)) * 4) | 32'($urandom_range(1, 3));
          default: flush_pc = 32'($urandom_range(0, 1023)) * 4;
        endcase
        ifu.ifu_ir_rdy  = ($urandom_range(0, 9) < 7);
        ifu.ifu_cmd_rdy = ($urandom_range(0, 3) != 0);
      end else begin
        halt_req = 1'b1; flush_req = 1'b0;
        ifu.ifu_ir_rdy = 1'b1; ifu.ifu_cmd_rdy = 1'b1;
      end
      if (!(ifu.ifu_rsp_vld && !taken)) begin
        if (bq.size() > 0 && bq[0].due <= cyc) begin
          ifu.ifu_rsp_vld  = 1'b1;
          ifu.ifu_rsp_data = bq[0].data;
          ifu.ifu_rsp_err  = bq[0].err;
        end else begin
          ifu.ifu_rsp_vld  = 1'b0;
          ifu.ifu_rsp_data = $urandom;
          ifu.ifu_rsp_err  = 1'b0;
        end
      end
      taken = 1'b0;

      #2;
      cmd_hs = ifu.ifu_cmd_vld & ifu.ifu_cmd_rdy;
      rsp_hs = ifu.ifu_rsp_vld & ifu.ifu_rsp_rdy;
      chk1("cmd_vld", ifu.ifu_cmd_vld,
           !flush_req && !halt_req && !mstop && (mcnt < P_OUTS) && (mpc[1:0] == 2'b00));
      chk1("halt_ack", halt_ack, halt_req && (mcnt == 0));
      chk1("flush_ack", flush_ack, flush_req);
      if (cmd_hs) chk("cmd_addr", ifu.ifu_cmd_addr, mpc);

      if (rsp_hs && bq.size() > 0) begin
        b = bq.pop_front();
        taken = 1'b1;
        if (b.epoch == epoch) begin
          mcnt--;
          if (!flush_req) begin
            exp_q.push_back('{ir: (b.err ? 32'h0 : b.data), pc: b.addr,
                              misalgn: 1'b0, buserr: b.err});
            if (b.err) mstop = 1'b1;
          end
        end
      end
      if (cmd_hs) begin
        bq.push_back('{addr: mpc, epoch: epoch, data: $urandom,
                       err: ($urandom_range(0, 24) == 0),
                       due: cyc + 1 + int'($urandom_range(0, 3))});
        mpc  = mpc + 32'd4;
        mcnt++;
      end
      if (flush_req) begin
        exp_q.delete();
        epoch++;
        mpc   = flush_pc;
        mcnt  = 0;
        mstop = (flush_pc[1:0] != 2'b00);
        if (mstop) exp_q.push_back('{ir: 32'h0, pc: flush_pc, misalgn: 1'b1, buserr: 1'b0});
      end

      cyc++;
      if (!draining && cyc >= N_RAND) draining = 1'b1;
      if (draining) begin
        drain++;
        if (bq.size() == 0 && exp_q.size() == 0 && mcnt == 0 && !taken) done = 1'b1;
        else if (drain > 400) begin
          total++;
          bad++;
          $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
          done = 1'b1;
        end
      end
      @(negedge clk);
    end

    #3;
    chk1("drain_empty", exp_q.size() == 0, 1'b1);
    chk1("delivered_enough", delivered >= 100, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
